// File: rtl/seq_barrel_shifter.sv
// Iterative barrel shifter with valid/ready handshakes: one bit position per clock.
// Optional BSHIFT_ARITH_EN enables sign-filling arithmetic right shift for mode 10.
module seq_barrel_shifter #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  input  logic             in_lr,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_data;
  logic [AMT_W-1:0] r_cnt;
  logic             r_lr;
  logic [1:0]       r_mode;
  logic             w_accept;
  logic             w_step;

  // Single-position step; reserved mode 11 falls through to logical.
  function automatic logic [WIDTH-1:0] f_step(input logic [WIDTH-1:0] d,
                                              input logic             lr,
                                              input logic [1:0]       mode);
    logic [WIDTH-1:0] res;
    if (lr) begin
      res = (mode == 2'b01) ? {d[WIDTH-2:0], d[WIDTH-1]} : {d[WIDTH-2:0], 1'b0};
    end else if (mode == 2'b01) begin
      res = {d[0], d[WIDTH-1:1]};
`ifdef BSHIFT_ARITH_EN
    end else if (mode == 2'b10) begin
      res = {d[WIDTH-1], d[WIDTH-1:1]};
`endif
    end else begin
      res = {1'b0, d[WIDTH-1:1]};
    end
    return res;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b1;
    w_accept    = 1'b0;
    w_step      = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        w_accept = in_valid;
        if (in_valid) w_state_nxt = SHIFT;
      end
      SHIFT: begin
        if (r_cnt == '0) w_state_nxt = HOLD;
        else             w_step      = 1'b1;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Operand capture on accept, then one step per SHIFT cycle while cnt is nonzero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
      r_cnt  <= '0;
      r_lr   <= 1'b0;
      r_mode <= 2'b00;
    end else if (w_accept) begin
      r_data <= in_data;
      r_cnt  <= in_amt;
      r_lr   <= in_lr;
      r_mode <= in_mode;
    end else if (w_step) begin
      r_data <= f_step(r_data, r_lr, r_mode);
      r_cnt  <= r_cnt - 1'b1;
    end
  end

  assign out_data = r_data;

endmodule

// File: tb/tb_seq_barrel_shifter.sv
// Scoreboard bench for seq_barrel_shifter: expected words queued at accept, checked at out_valid.
module tb_seq_barrel_shifter;
  localparam int WIDTH = 8;
  localparam int AMT_W = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic [AMT_W-1:0] in_amt = '0;
  logic             in_lr = 1'b0;
  logic [1:0]       in_mode = 2'b00;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic             busy;

  seq_barrel_shifter #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_amt(in_amt), .in_lr(in_lr), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [WIDTH-1:0] d;
    int               amt;
    int               k;
  } exp_t;
  exp_t sb[$];

  int n_chk = 0;
  int n_err = 0;
  int last_wait = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] d, input int amt,
                                             input logic lr, input logic [1:0] mode);
    logic [2*WIDTH-1:0]      dd;
    logic signed [WIDTH-1:0] s;
    logic [WIDTH-1:0]        r;
    dd = {d, d};
    s  = d;
    if (mode == 2'b01) begin
      if (lr) begin
        dd = dd << amt;
        r  = dd[2*WIDTH-1:WIDTH];
      end else begin
        dd = dd >> amt;
        r  = dd[WIDTH-1:0];
      end
    end else if (lr) begin
      r = d << amt;
`ifdef BSHIFT_ARITH_EN
    end else if (mode == 2'b10) begin
      r = s >>> amt;
`endif
    end else begin
      r = d >> amt;
    end
    return r;
  endfunction

  task automatic send(input logic [WIDTH-1:0] d, input int amt, input logic lr,
                      input logic [1:0] mode);
    exp_t e;
    int   n;
    in_valid = 1'b1;
    in_data  = d;
    in_amt   = amt[AMT_W-1:0];
    in_lr    = lr;
    in_mode  = mode;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    last_wait = n;
    if (!in_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      return;
    end
    e.d   = model(d, amt, lr, mode);
    e.amt = amt;
    e.k   = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = $urandom;
    in_amt   = $urandom;
    in_lr    = $urandom;
    in_mode  = $urandom;
  endtask

  task automatic recv(input int stall, input string tag);
    exp_t e;
    int   n;
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) begin
      chk({tag, "_valid_timeout"}, 32'd0, 32'd1);
      if (sb.size() > 0) void'(sb.pop_front());
      return;
    end
    if (sb.size() == 0) begin
      chk({tag, "_unexpected_out"}, 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_data"}, out_data, e.d);
    chk({tag, "_latency"}, cyc - e.k, e.amt + 1);
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1;
      in_data  = $urandom;
      @(negedge clk);
      chk({tag, "_hold_valid"}, out_valid, 1'b1);
      chk({tag, "_hold_data"}, out_data, e.d);
      chk({tag, "_hold_in_ready"}, in_ready, 1'b0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_post_valid"}, out_valid, 1'b0);
    chk({tag, "_post_in_ready"}, in_ready, 1'b1);
  endtask

  initial begin
    int bad;
    #2;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, '0);
    chk("rst_busy", busy, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    send(8'b10101010, 1, 1'b1, 2'b01);
    recv(0, "rot_left");
    chk("rot_left_value", model(8'b10101010, 1, 1'b1, 2'b01), 8'b01010101);

    send(8'b11101010, 3, 1'b0, 2'b00);
    recv(0, "lsr");

    send(8'b11101010, 3, 1'b0, 2'b10);
    recv(0, "asr");

    send(8'b11101010, 2, 1'b1, 2'b11);
    recv(0, "reserved_mode");

    send(8'b00000010, 0, 1'b0, 2'b00);
    recv(0, "zero_amt");
    send(8'b10000001, 0, 1'b0, 2'b01);
    chk("b2b_accept_wait", last_wait, 0);
    recv(0, "b2b");

    send(8'b01100110, 4, 1'b0, 2'b01);
    recv(5, "backpressure");

    send(8'b11110000, 4, 1'b1, 2'b00);
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("early_ready_valid", out_valid, 1'b0);
    chk("early_ready_busy", busy, 1'b1);
    out_ready = 1'b0;
    recv(0, "early_ready");

    send(8'b11001010, 7, 1'b0, 2'b10);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", in_ready, 1'b1);
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_out_data", out_data, '0);
    chk("midrst_busy", busy, 1'b0);
    void'(sb.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid || busy) bad++;
    end
    chk("midrst_no_stale", bad, 0);
    send(8'b10010110, 5, 1'b1, 2'b01);
    recv(0, "after_rst");

    for (int t = 0; t < 24; t++) begin
      send(WIDTH'($urandom), $urandom_range(0, (1 << AMT_W) - 1), 1'($urandom),
           2'($urandom));
      recv($urandom_range(0, 2), "rand");
    end

    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1);
  end

endmodule
